// File: rtl/instr_pkg.sv
// Shared opcode constants, fetch state encoding and instruction-length helper.
package instr_pkg;

    localparam int unsigned OPC_WIDTH = 8;

    localparam logic [OPC_WIDTH-1:0] LDACI = 8'd0;
    localparam logic [OPC_WIDTH-1:0] MVAC  = 8'd4;
    localparam logic [OPC_WIDTH-1:0] STACI = 8'd13;
    localparam logic [OPC_WIDTH-1:0] JPNZ  = 8'd27;
    localparam logic [OPC_WIDTH-1:0] ENDOP = 8'd28;
    localparam logic [OPC_WIDTH-1:0] JMPZ  = 8'd47;
    localparam logic [OPC_WIDTH-1:0] NOP   = 8'd48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_LATCH_OP,
        ST_FETCH_OPND,
        ST_LATCH_OPND,
        ST_PRESENT,
        ST_HALT
    } fetch_state_t;

    // Opcodes followed by an immediate operand byte.
    function automatic logic is_two_byte(input logic [OPC_WIDTH-1:0] op);
        return (op == LDACI) || (op == STACI) || (op == JPNZ) || (op == JMPZ);
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length decode: flags two-byte opcodes and, when
// INSTR_FETCH_ILLEGAL_OP_TRAP_EN is defined, opcodes beyond NOP.
module instr_len_decode
    import instr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] opcode,
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
    output logic                  illegal_c,
`endif
    output logic                  has_operand_c
);

    assign has_operand_c = is_two_byte(OPC_WIDTH'(opcode));

`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
    assign illegal_c = (opcode > DATA_WIDTH'(NOP));
`endif

endmodule

// File: rtl/instr_fetch.sv
// Per-core instruction fetch: owns the PC, reads opcode/operand bytes from the
// instruction memory read port and presents them over valid/ready.
// Optional illegal-opcode trap: INSTR_FETCH_ILLEGAL_OP_TRAP_EN.
module instr_fetch
    import instr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_instr,
    input  logic                  wr_busy,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  has_operand,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    fetch_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [ADDR_WIDTH-1:0] pc_plus1, pc_step;
    logic [DATA_WIDTH-1:0] opcode_nxt, operand_nxt;
    logic [ADDR_WIDTH-1:0] instr_pc_nxt;
    logic                  has_operand_nxt;
    logic                  instr_valid_nxt;
    logic                  halted_nxt;
    logic                  dec_has_operand_c;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
    logic                  dec_illegal_c;
    logic                  illegal_q, illegal_nxt;
`endif

    // Sequential PC arithmetic, wrapping at the address width.
    assign pc_plus1 = pc + ADDR_WIDTH'(1);
    assign pc_step  = has_operand ? (pc + ADDR_WIDTH'(2)) : pc_plus1;

    // Operand byte lives at pc+1; every other state reads at pc.
    assign r_addr = ((state == ST_LATCH_OP) || (state == ST_FETCH_OPND)) ? pc_plus1 : pc;

    // Length decode of the byte currently on the read port.
    instr_len_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_len_decode (
        .opcode        (r_instr),
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
        .illegal_c     (dec_illegal_c),
`endif
        .has_operand_c (dec_has_operand_c)
    );

`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        opcode_nxt      = opcode;
        operand_nxt     = operand;
        has_operand_nxt = has_operand;
        instr_pc_nxt    = instr_pc;
        halted_nxt      = halted;
        instr_valid_nxt = 1'b0;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
        illegal_nxt     = illegal_q;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt    = PC_INIT;
                    state_nxt = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (!wr_busy) state_nxt = ST_LATCH_OP;
            end
            ST_LATCH_OP: begin
                opcode_nxt      = r_instr;
                instr_pc_nxt    = pc;
                has_operand_nxt = dec_has_operand_c;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
                if (dec_illegal_c) begin
                    has_operand_nxt = 1'b0;
                    operand_nxt     = '0;
                    halted_nxt      = 1'b1;
                    illegal_nxt     = 1'b1;
                    state_nxt       = ST_HALT;
                end else
`endif
                if (dec_has_operand_c) begin
                    state_nxt = wr_busy ? ST_FETCH_OPND : ST_LATCH_OPND;
                end else begin
                    operand_nxt = '0;
                    state_nxt   = ST_PRESENT;
                end
            end
            ST_FETCH_OPND: begin
                if (!wr_busy) state_nxt = ST_LATCH_OPND;
            end
            ST_LATCH_OPND: begin
                operand_nxt = r_instr;
                state_nxt   = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instr_ready) begin
                    if (opcode == DATA_WIDTH'(ENDOP)) begin
                        halted_nxt = 1'b1;
                        state_nxt  = ST_HALT;
                    end else if (jump_en) begin
                        pc_nxt    = jump_addr;
                        state_nxt = ST_FETCH_OP;
                    end else begin
                        pc_nxt    = pc_step;
                        state_nxt = ST_FETCH_OP;
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    halted_nxt = 1'b0;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
                    illegal_nxt = 1'b0;
`endif
                    pc_nxt     = PC_INIT;
                    state_nxt  = ST_FETCH_OP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        instr_valid_nxt = (state_nxt == ST_PRESENT);
    end

    // State, PC and presented-instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= PC_INIT;
            opcode      <= '0;
            operand     <= '0;
            has_operand <= 1'b0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            opcode      <= opcode_nxt;
            operand     <= operand_nxt;
            has_operand <= has_operand_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            halted      <= halted_nxt;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
            illegal_q   <= illegal_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural instruction memory plus a scoreboard of
// expected presented instructions, popped on every valid/ready handshake.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] r_addr;
    logic [7:0] r_instr;
    logic       wr_busy = 1'b0;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic       has_operand;
    logic [7:0] instr_pc;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic       halted;
    logic       illegal;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] opnd;
        logic       has;
        logic [7:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [7:0] mem [0:255];
    int         checks = 0;
    int         errors = 0;
    int         n_acc  = 0;

    instr_fetch #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .RESET_PC   (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .r_addr      (r_addr),
        .r_instr     (r_instr),
        .wr_busy     (wr_busy),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .has_operand (has_operand),
        .instr_pc    (instr_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Registered-read memory port; read data frozen while the port is writing.
    always @(posedge clk) begin
        if (!wr_busy) r_instr <= mem[r_addr];
    end

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: got op=%0d pc=%0d, expected no instruction", opcode, instr_pc);
            end else begin
                cur = exp_q.pop_front();
                checks += 4;
                if (opcode !== cur.opc) begin
                    errors++; $display("FAIL sb_opcode: got %0d expected %0d (pc %0d)", opcode, cur.opc, cur.pc);
                end
                if (operand !== cur.opnd) begin
                    errors++; $display("FAIL sb_operand: got %0h expected %0h (pc %0d)", operand, cur.opnd, cur.pc);
                end
                if (has_operand !== cur.has) begin
                    errors++; $display("FAIL sb_has_operand: got %0b expected %0b (pc %0d)", has_operand, cur.has, cur.pc);
                end
                if (instr_pc !== cur.pc) begin
                    errors++; $display("FAIL sb_instr_pc: got %0d expected %0d", instr_pc, cur.pc);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] o, input logic [7:0] d, input logic h, input logic [7:0] p);
        exp_t e;
        e.opc = o; e.opnd = d; e.has = h; e.pc = p;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_halted(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Hold ready low until valid, then accept for exactly one cycle.
    task automatic accept(input bit jmp, input logic [7:0] addr, output bit ok);
        wait_valid(ok);
        if (ok) begin
            @(posedge clk); #1;
            instr_ready = 1'b1; jump_en = jmp; jump_addr = addr;
            @(posedge clk); #1;
            instr_ready = 1'b0; jump_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 7;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b expected 0", illegal); end
        if (opcode !== 8'h00) begin errors++; $display("FAIL rst_opcode: got %0h expected 0", opcode); end
        if (operand !== 8'h00) begin errors++; $display("FAIL rst_operand: got %0h expected 0", operand); end
        if (has_operand !== 1'b0) begin errors++; $display("FAIL rst_has_operand: got %b expected 0", has_operand); end
        if (r_addr !== 8'h00) begin errors++; $display("FAIL rst_r_addr: got %0h expected 0", r_addr); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        mem[0] = 8'd0; mem[1] = 8'h00; mem[2] = 8'd4; mem[3] = 8'd28;
        push_exp(8'd0, 8'h00, 1'b1, 8'd0);
        push_exp(8'd4, 8'h00, 1'b0, 8'd2);
        push_exp(8'd28, 8'h00, 1'b0, 8'd3);
        instr_ready = 1'b1;
        pulse_start();
        tick(); tick();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", instr_valid); end
        tick();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", instr_valid); end
        wait_halted(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_halt: got halted=%b expected 1", halted); end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_no_valid: got %b expected 0", instr_valid); end
        end
        instr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_halt_restart();
        bit ok;
        mem[0] = 8'd4; mem[1] = 8'd28;
        push_exp(8'd4, 8'h00, 1'b0, 8'd0);
        push_exp(8'd28, 8'h00, 1'b0, 8'd1);
        instr_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        checks += 2;
        if (r_addr !== 8'd0) begin errors++; $display("FAIL restart_r_addr: got %0d expected 0", r_addr); end
        if (halted !== 1'b0) begin errors++; $display("FAIL restart_halted: got %b expected 0", halted); end
        wait_halted(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL restart_halt: got halted=%b expected 1", halted); end
        instr_ready = 1'b0;
    endtask

    task automatic test_jump();
        bit ok;
        mem[0] = 8'd27; mem[1] = 8'd87;
        mem[87] = 8'd27; mem[88] = 8'd53;
        mem[53] = 8'd47; mem[54] = 8'd87;
        mem[89] = 8'd4;  mem[90] = 8'd28;
        push_exp(8'd27, 8'd87, 1'b1, 8'd0);
        push_exp(8'd27, 8'd53, 1'b1, 8'd87);
        push_exp(8'd47, 8'd87, 1'b1, 8'd53);
        push_exp(8'd27, 8'd53, 1'b1, 8'd87);
        push_exp(8'd4,  8'h00, 1'b0, 8'd89);
        push_exp(8'd28, 8'h00, 1'b0, 8'd90);
        pulse_start();
        accept(1'b1, 8'd87, ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_hs0: got timeout expected valid"); end
        accept(1'b1, 8'd53, ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_hs1: got timeout expected valid"); end
        checks++;
        if (r_addr !== 8'd53) begin errors++; $display("FAIL jump_r_addr: got %0d expected 53", r_addr); end
        accept(1'b1, 8'd87, ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_hs2: got timeout expected valid"); end
        accept(1'b0, 8'd53, ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_hs3: got timeout expected valid"); end
        checks++;
        if (r_addr !== 8'd89) begin errors++; $display("FAIL nojump_r_addr: got %0d expected 89", r_addr); end
        accept(1'b0, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_hs4: got timeout expected valid"); end
        accept(1'b0, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_hs5: got timeout expected valid"); end
        wait_halted(ok);
        checks++; if (!ok) begin errors++; $display("FAIL jump_halt: got halted=%b expected 1", halted); end
    endtask

    task automatic test_stall();
        bit ok;
        mem[0] = 8'd0; mem[1] = 8'h5A; mem[2] = 8'd28;
        push_exp(8'd0, 8'h5A, 1'b1, 8'd0);
        push_exp(8'd28, 8'h00, 1'b0, 8'd2);
        pulse_start();
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_valid: got timeout expected valid"); end
        jump_en = 1'b1; jump_addr = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            checks += 4;
            if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_hold: got %b expected 1", instr_valid); end
            if (opcode !== 8'd0) begin errors++; $display("FAIL stall_opcode: got %0d expected 0", opcode); end
            if (operand !== 8'h5A) begin errors++; $display("FAIL stall_operand: got %0h expected 5a", operand); end
            if (r_addr !== 8'd0) begin errors++; $display("FAIL stall_pc: got %0d expected 0", r_addr); end
        end
        jump_en = 1'b0;
        accept(1'b0, 8'd0, ok);
        checks++;
        if (r_addr !== 8'd2) begin errors++; $display("FAIL stall_next_pc: got %0d expected 2", r_addr); end
        accept(1'b0, 8'd0, ok);
        wait_halted(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_halt: got halted=%b expected 1", halted); end
    endtask

    task automatic test_wr_busy();
        bit ok;
        mem[0] = 8'd13; mem[1] = 8'h33; mem[2] = 8'd28;
        push_exp(8'd13, 8'h33, 1'b1, 8'd0);
        push_exp(8'd28, 8'h00, 1'b0, 8'd2);
        instr_ready = 1'b1;
        pulse_start();
        wr_busy = 1'b1;
        tick(); tick();
        wr_busy = 1'b0;
        tick();
        wr_busy = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (r_addr !== 8'd1) begin errors++; $display("FAIL busy_opnd_addr: got %0d expected 1", r_addr); end
        wr_busy = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL busy_early_valid: got %b expected 0", instr_valid); end
        tick();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL busy_latency: got %b expected 1", instr_valid); end
        wait_halted(ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_halt: got halted=%b expected 1", halted); end
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        mem[0] = 8'd4; mem[1] = 8'd27; mem[2] = 8'd255; mem[3] = 8'd28; mem[255] = 8'd0;
        push_exp(8'd4,  8'h00,  1'b0, 8'd0);
        push_exp(8'd27, 8'd255, 1'b1, 8'd1);
        push_exp(8'd0,  8'd4,   1'b1, 8'd255);
        push_exp(8'd27, 8'd255, 1'b1, 8'd1);
        push_exp(8'd28, 8'h00,  1'b0, 8'd3);
        pulse_start();
        accept(1'b0, 8'd0, ok);
        accept(1'b1, 8'd255, ok);
        accept(1'b0, 8'd0, ok);
        checks++;
        if (r_addr !== 8'd1) begin errors++; $display("FAIL wrap_next_pc: got %0d expected 1", r_addr); end
        accept(1'b0, 8'd0, ok);
        accept(1'b0, 8'd0, ok);
        wait_halted(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_halt: got halted=%b expected 1", halted); end
    endtask

    task automatic test_illegal();
        bit ok;
`ifdef INSTR_FETCH_ILLEGAL_OP_TRAP_EN
        mem[0] = 8'd60;
        pulse_start();
        wait_halted(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL trap_halted: got %b expected 1", halted); end
        if (illegal !== 1'b1) begin errors++; $display("FAIL trap_illegal: got %b expected 1", illegal); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL trap_valid: got %b expected 0", instr_valid); end
        mem[0] = 8'd28;
        push_exp(8'd28, 8'h00, 1'b0, 8'd0);
        instr_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b expected 0", illegal); end
        wait_halted(ok);
        checks++; if (!ok) begin errors++; $display("FAIL trap_resume: got halted=%b expected 1", halted); end
`else
        mem[0] = 8'd60; mem[1] = 8'd28;
        push_exp(8'd60, 8'h00, 1'b0, 8'd0);
        push_exp(8'd28, 8'h00, 1'b0, 8'd1);
        instr_ready = 1'b1;
        pulse_start();
        wait_halted(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL op60_halt: got halted=%b expected 1", halted); end
        if (illegal !== 1'b0) begin errors++; $display("FAIL op60_illegal: got %b expected 0", illegal); end
`endif
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem[0] = 8'd13; mem[1] = 8'h77;
        instr_ready = 1'b1;
        pulse_start();
        tick(); tick();
        rst = 1'b1;
        #1;
        checks += 5;
        if (opcode !== 8'h00) begin errors++; $display("FAIL midrst_opcode: got %0d expected 0", opcode); end
        if (has_operand !== 1'b0) begin errors++; $display("FAIL midrst_has_operand: got %b expected 0", has_operand); end
        if (operand !== 8'h00) begin errors++; $display("FAIL midrst_operand: got %0h expected 0", operand); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", instr_valid); end
        if (r_addr !== 8'h00) begin errors++; $display("FAIL midrst_r_addr: got %0d expected 0", r_addr); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_abandon: got %b expected 0", instr_valid); end
        end
        instr_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd48;
        test_reset();
        test_basic();
        test_halt_restart();
        test_jump();
        test_stall();
        test_wr_busy();
        test_wrap();
        test_illegal();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
